// File: rtl/usb_reg_responder.sv
// ---------------------------------------------------------------------------
// usb_reg_responder
//
// Target end of the parallel USB register bus. Synchronizes the host strobes
// into clk_usb, decodes them into single-cycle register-access pulses, keeps
// the auto-incrementing byte counter for multi-byte bursts, and returns read
// data to the top-level tristate pad.
//
// Ports:
//   clk_usb, reset_n         clock (rising edge), async active-low reset
//   USB_Addr, usb_din        host address / write data (sampled one flop deep)
//   USB_RDn/WRn/CEn/ALEn     active-low host strobes (synchronized)
//   usb_dout, usb_isout      read data to the pad and its output enable
//   reg_address, reg_bytecnt latched register address, byte index in burst
//   reg_addrvalid            set by the first address phase after reset
//   reg_datao, reg_write     write data and its one-cycle strobe
//   reg_read, reg_datai      one-cycle read request, data returned next cycle
//   bus_error                sticky protocol error, cleared by an address phase
//
// pSYNC_STAGES must be 2 or 3.
// ---------------------------------------------------------------------------
module usb_reg_responder #(
    parameter int pBYTECNT_SIZE = 7,
    parameter int pSYNC_STAGES  = 2
) (
    input  logic                     clk_usb,
    input  logic                     reset_n,
    input  logic [7:0]               USB_Addr,
    input  logic                     USB_RDn,
    input  logic                     USB_WRn,
    input  logic                     USB_CEn,
    input  logic                     USB_ALEn,
    input  logic [7:0]               usb_din,
    output logic [7:0]               usb_dout,
    output logic                     usb_isout,
    output logic [7:0]               reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic                     reg_addrvalid,
    output logic [7:0]               reg_datao,
    output logic                     reg_write,
    output logic                     reg_read,
    input  logic [7:0]               reg_datai,
    output logic                     bus_error
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WRITE,
        RD_REQ,
        RD_DRIVE
    } state_t;

    state_t state, nxt_state;

    // Strobe synchronizers; they reset to 1 so the bus looks idle.
    logic [pSYNC_STAGES-1:0] rdn_sync, wrn_sync, cen_sync, alen_sync;
    logic s_rdn, s_wrn, s_cen, s_alen;
    logic s_rdn_d, s_wrn_d, s_alen_d;
    logic [7:0] addr_q, din_q;

    assign s_rdn  = rdn_sync[pSYNC_STAGES-1];
    assign s_wrn  = wrn_sync[pSYNC_STAGES-1];
    assign s_cen  = cen_sync[pSYNC_STAGES-1];
    assign s_alen = alen_sync[pSYNC_STAGES-1];

    always_ff @(posedge clk_usb or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!reset_n) begin
            rdn_sync  <= '1;
            wrn_sync  <= '1;
            cen_sync  <= '1;
            alen_sync <= '1;
            s_rdn_d   <= 1'b1;
            s_wrn_d   <= 1'b1;
            s_alen_d  <= 1'b1;
            addr_q    <= '0;
            din_q     <= '0;
        end else begin
            rdn_sync  <= {rdn_sync[pSYNC_STAGES-2:0],  USB_RDn};
            wrn_sync  <= {wrn_sync[pSYNC_STAGES-2:0],  USB_WRn};
            cen_sync  <= {cen_sync[pSYNC_STAGES-2:0],  USB_CEn};
            alen_sync <= {alen_sync[pSYNC_STAGES-2:0], USB_ALEn};
            s_rdn_d   <= s_rdn;
            s_wrn_d   <= s_wrn;
            s_alen_d  <= s_alen;
            // Address/data need no synchronizer: the host holds them stable
            // around the strobe, so a single sampling flop is enough.
            addr_q    <= USB_Addr;
            din_q     <= usb_din;
        end
    end

    // Falling edges of the synchronized strobes, ignored while deselected.
    logic rd_fall, wr_fall, ale_fall;
    assign rd_fall  = s_rdn_d  & ~s_rdn  & ~s_cen;
    assign wr_fall  = s_wrn_d  & ~s_wrn  & ~s_cen;
    assign ale_fall = s_alen_d & ~s_alen & ~s_cen;

    logic [7:0]               nxt_address, nxt_datao, nxt_dout;
    logic [pBYTECNT_SIZE-1:0] nxt_bytecnt;
    logic                     nxt_addrvalid, nxt_write, nxt_read, nxt_isout, nxt_error;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        nxt_state     = state;
        nxt_address   = reg_address;
        nxt_bytecnt   = reg_bytecnt;
        nxt_addrvalid = reg_addrvalid;
        nxt_datao     = reg_datao;
        nxt_write     = 1'b0;
        nxt_read      = 1'b0;
        nxt_dout      = usb_dout;
        nxt_isout     = usb_isout;
        nxt_error     = bus_error;

        case (state)
            IDLE: begin
                nxt_isout = 1'b0;
                if (ale_fall) begin
                    nxt_state     = ADDR;
                    nxt_address   = addr_q;
                    nxt_bytecnt   = '0;
                    nxt_addrvalid = 1'b1;
                    nxt_error     = 1'b0;
                end else if (wr_fall) begin
                    // Write wins over a simultaneous read, but it is flagged.
                    nxt_state = WRITE;
                    nxt_datao = din_q;
                    if (!s_rdn) nxt_error = 1'b1;
                end else if (rd_fall) begin
                    nxt_state = RD_REQ;
                    nxt_read  = 1'b1;
                end
            end

            ADDR: begin
                if (s_cen || s_alen) nxt_state = IDLE;
                else                 nxt_address = addr_q;
            end

            WRITE: begin
                if (rd_fall || ale_fall) nxt_error = 1'b1;
                if (reg_write) begin
                    // Pulse already issued: count the byte and finish.
                    nxt_bytecnt = reg_bytecnt + pBYTECNT_SIZE'(1);
                    nxt_state   = IDLE;
                end else if (s_cen) begin
                    nxt_state = IDLE;
                end else if (s_wrn) begin
                    nxt_write = 1'b1;
                end else begin
                    nxt_datao = din_q;
                end
            end

            RD_REQ: begin
                if (wr_fall || ale_fall) nxt_error = 1'b1;
                if (s_cen) begin
                    nxt_state = IDLE;
                end else begin
                    nxt_state = RD_DRIVE;
                    nxt_dout  = reg_datai;
                    nxt_isout = 1'b1;
                end
            end

            RD_DRIVE: begin
                if (wr_fall || ale_fall) nxt_error = 1'b1;
                if (s_cen) begin
                    nxt_isout = 1'b0;
                    nxt_state = IDLE;
                end else if (s_rdn) begin
                    nxt_isout   = 1'b0;
                    nxt_bytecnt = reg_bytecnt + pBYTECNT_SIZE'(1);
                    nxt_state   = IDLE;
                end
            end

            default: nxt_state = IDLE;
        endcase
    end

    // All bus-facing outputs are registered; reset drops usb_isout at once.
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            reg_address   <= '0;
            reg_bytecnt   <= '0;
            reg_addrvalid <= 1'b0;
            reg_datao     <= '0;
            reg_write     <= 1'b0;
            reg_read      <= 1'b0;
            usb_dout      <= '0;
            usb_isout     <= 1'b0;
            bus_error     <= 1'b0;
        end else begin
            state         <= nxt_state;
            reg_address   <= nxt_address;
            reg_bytecnt   <= nxt_bytecnt;
            reg_addrvalid <= nxt_addrvalid;
            reg_datao     <= nxt_datao;
            reg_write     <= nxt_write;
            reg_read      <= nxt_read;
            usb_dout      <= nxt_dout;
            usb_isout     <= nxt_isout;
            bus_error     <= nxt_error;
        end
    end

endmodule

// File: tb/tb_usb_reg_responder.sv
// ---------------------------------------------------------------------------
// tb_usb_reg_responder
//
// Directed host transactions drive the pins from the negative clock edge.
// Each issued byte pushes its expected register access into a queue; an
// independent monitor sampling 1 time unit after each rising edge pops and
// compares whenever the DUT pulses reg_write or raises usb_isout.
// ---------------------------------------------------------------------------
module tb_usb_reg_responder;

    localparam int N = 2;   // pSYNC_STAGES
    localparam int W = 7;   // pBYTECNT_SIZE

    logic         clk_usb = 1'b0;
    logic         reset_n;
    logic [7:0]   USB_Addr;
    logic         USB_RDn, USB_WRn, USB_CEn, USB_ALEn;
    logic [7:0]   usb_din;
    logic [7:0]   usb_dout;
    logic         usb_isout;
    logic [7:0]   reg_address;
    logic [W-1:0] reg_bytecnt;
    logic         reg_addrvalid;
    logic [7:0]   reg_datao;
    logic         reg_write;
    logic         reg_read;
    logic [7:0]   reg_datai;
    logic         bus_error;

    usb_reg_responder #(.pBYTECNT_SIZE(W), .pSYNC_STAGES(N)) dut (
        .clk_usb       (clk_usb),
        .reset_n       (reset_n),
        .USB_Addr      (USB_Addr),
        .USB_RDn       (USB_RDn),
        .USB_WRn       (USB_WRn),
        .USB_CEn       (USB_CEn),
        .USB_ALEn      (USB_ALEn),
        .usb_din       (usb_din),
        .usb_dout      (usb_dout),
        .usb_isout     (usb_isout),
        .reg_address   (reg_address),
        .reg_bytecnt   (reg_bytecnt),
        .reg_addrvalid (reg_addrvalid),
        .reg_datao     (reg_datao),
        .reg_write     (reg_write),
        .reg_read      (reg_read),
        .reg_datai     (reg_datai),
        .bus_error     (bus_error)
    );

    always #5 clk_usb = ~clk_usb;

    // Register-block model: registered read data equal to 0xA0 + byte index.
    always @(posedge clk_usb) reg_datai <= 8'hA0 + {1'b0, reg_bytecnt};

    typedef struct {
        logic [7:0]   addr;
        logic [W-1:0] cnt;
        logic [7:0]   data;
    } wr_exp_t;

    wr_exp_t    wr_q[$];
    logic [7:0] rd_q[$];

    int tests_run = 0;
    int tests_failed = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    int rdn_high_cnt = 100;
    logic isout_prev = 1'b0;

    logic [7:0]   exp_addr = 8'h00;
    logic [W-1:0] exp_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard.
    always @(posedge clk_usb) begin
        #1;
        if (USB_RDn) rdn_high_cnt++;
        else         rdn_high_cnt = 0;
        if (reset_n) begin
            if (reg_write || reg_read)
                check("wr_rd_exclusive", {31'd0, reg_write & reg_read}, 32'd0);
            if (reg_write) begin
                wr_pulses++;
                check("write_expected", {31'd0, wr_q.size() != 0}, 32'd1);
                if (wr_q.size() != 0) begin
                    wr_exp_t e;
                    e = wr_q.pop_front();
                    check("wr_address", {24'd0, reg_address}, {24'd0, e.addr});
                    check("wr_bytecnt", {25'd0, reg_bytecnt}, {25'd0, e.cnt});
                    check("wr_datao",   {24'd0, reg_datao},   {24'd0, e.data});
                end
            end
            if (reg_read) rd_pulses++;
            if (usb_isout && !isout_prev) begin
                check("read_expected", {31'd0, rd_q.size() != 0}, 32'd1);
                if (rd_q.size() != 0) begin
                    logic [7:0] d;
                    d = rd_q.pop_front();
                    check("rd_dout", {24'd0, usb_dout}, {24'd0, d});
                end
            end
            // usb_isout may trail the pin RDn release only by the synchronizer.
            if (usb_isout)
                check("isout_in_rdn_window", {31'd0, rdn_high_cnt <= N}, 32'd1);
        end
        isout_prev = usb_isout;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_usb);
    endtask

    task automatic set_addr(input logic [7:0] a);
        @(negedge clk_usb);
        USB_Addr = a;
        USB_ALEn = 1'b0;
        cycles(N + 3);
        USB_ALEn = 1'b1;
        cycles(N + 3);
        exp_addr = a;
        exp_cnt  = '0;
    endtask

    task automatic wr_byte(input logic [7:0] d);
        wr_q.push_back('{addr: exp_addr, cnt: exp_cnt, data: d});
        exp_cnt = exp_cnt + 1'b1;
        @(negedge clk_usb);
        usb_din = d;
        USB_WRn = 1'b0;
        cycles(N + 3);
        USB_WRn = 1'b1;
        cycles(N + 4);
    endtask

    task automatic rd_byte();
        rd_q.push_back(8'hA0 + {1'b0, exp_cnt});
        exp_cnt = exp_cnt + 1'b1;
        @(negedge clk_usb);
        USB_RDn = 1'b0;
        cycles(N + 4);
        USB_RDn = 1'b1;
        cycles(N + 4);
    endtask

    logic [7:0] wdata [4];
    logic [7:0] b;
    int wr_base, rd_base;

    initial begin
        wdata = '{8'h11, 8'h22, 8'h33, 8'h44};
        reset_n  = 1'b0;
        USB_Addr = 8'h00;
        USB_RDn  = 1'b1;
        USB_WRn  = 1'b1;
        USB_CEn  = 1'b0;
        USB_ALEn = 1'b1;
        usb_din  = 8'h00;
        cycles(3);
        reset_n = 1'b1;
        cycles(1);

        // Reset state.
        check("rst_isout",     {31'd0, usb_isout},     32'd0);
        check("rst_dout",      {24'd0, usb_dout},      32'd0);
        check("rst_address",   {24'd0, reg_address},   32'd0);
        check("rst_bytecnt",   {25'd0, reg_bytecnt},   32'd0);
        check("rst_addrvalid", {31'd0, reg_addrvalid}, 32'd0);
        check("rst_bus_error", {31'd0, bus_error},     32'd0);

        // Four-byte write burst to 0x2A.
        set_addr(8'h2A);
        check("addr_latched", {24'd0, reg_address},   32'h2A);
        check("addrvalid",    {31'd0, reg_addrvalid}, 32'd1);
        wr_base = wr_pulses;
        for (int i = 0; i < 4; i++) wr_byte(wdata[i]);
        check("burst_writes",  wr_pulses - wr_base,    32'd4);
        check("burst_bytecnt", {25'd0, reg_bytecnt},   32'd4);

        // Two-byte read burst from 0x05.
        set_addr(8'h05);
        rd_base = rd_pulses;
        rd_byte();
        rd_byte();
        check("read_pulses",  rd_pulses - rd_base,     32'd2);
        check("read_bytecnt", {25'd0, reg_bytecnt},    32'd2);
        check("read_isout",   {31'd0, usb_isout},      32'd0);

        // 130 writes: byte counter wraps 127 -> 0 silently.
        set_addr(8'h00);
        for (int i = 0; i < 130; i++) begin
            b = i[7:0];
            wr_byte(b);
        end
        check("wrap_bytecnt",   {25'd0, reg_bytecnt}, 32'd2);
        check("wrap_bus_error", {31'd0, bus_error},   32'd0);

        // RDn and WRn fall together: write wins, error flagged.
        set_addr(8'h33);
        wr_base = wr_pulses;
        rd_base = rd_pulses;
        wr_q.push_back('{addr: 8'h33, cnt: 7'd0, data: 8'h5A});
        @(negedge clk_usb);
        usb_din = 8'h5A;
        USB_WRn = 1'b0;
        USB_RDn = 1'b0;
        cycles(N + 3);
        USB_WRn = 1'b1;
        USB_RDn = 1'b1;
        cycles(N + 4);
        check("both_writes",    wr_pulses - wr_base, 32'd1);
        check("both_reads",     rd_pulses - rd_base, 32'd0);
        check("both_bus_error", {31'd0, bus_error},  32'd1);
        set_addr(8'h34);
        check("ale_clears_error", {31'd0, bus_error}, 32'd0);

        // CEn rises mid-write: aborted, no pulse, counter untouched.
        wr_base = wr_pulses;
        @(negedge clk_usb);
        usb_din = 8'hEE;
        USB_WRn = 1'b0;
        cycles(N + 3);
        USB_CEn = 1'b1;
        cycles(N + 3);
        USB_WRn = 1'b1;
        cycles(N + 3);
        USB_CEn = 1'b0;
        cycles(N + 3);
        check("abort_writes",  wr_pulses - wr_base,  32'd0);
        check("abort_bytecnt", {25'd0, reg_bytecnt}, 32'd0);
        wr_byte(8'h77);
        check("post_abort_bytecnt", {25'd0, reg_bytecnt}, 32'd1);

        // Reset during RD_DRIVE.
        set_addr(8'h06);
        rd_q.push_back(8'hA0);
        @(negedge clk_usb);
        USB_RDn = 1'b0;
        for (int i = 0; i < 20 && !usb_isout; i++) @(negedge clk_usb);
        check("rd_drive_reached", {31'd0, usb_isout}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrd_isout",     {31'd0, usb_isout},     32'd0);
        check("midrd_dout",      {24'd0, usb_dout},      32'd0);
        check("midrd_address",   {24'd0, reg_address},   32'd0);
        check("midrd_addrvalid", {31'd0, reg_addrvalid}, 32'd0);
        check("midrd_bytecnt",   {25'd0, reg_bytecnt},   32'd0);
        check("midrd_datao",     {24'd0, reg_datao},     32'd0);
        USB_RDn = 1'b1;
        cycles(2);
        reset_n = 1'b1;
        cycles(2);
        set_addr(8'h10);
        wr_byte(8'h99);
        check("post_rst_address", {24'd0, reg_address}, 32'h10);
        check("post_rst_bytecnt", {25'd0, reg_bytecnt}, 32'd1);

        // Drain the scoreboard.
        for (int i = 0; i < 50 && (wr_q.size() != 0 || rd_q.size() != 0); i++)
            @(negedge clk_usb);
        check("wr_queue_drained", wr_q.size(), 32'd0);
        check("rd_queue_drained", rd_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
